mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the control unit's MOV/RW/MOC handshake. Accepts a request from the datapath (address from MAR, write data from MDR, access size, read/write), inserts a parameterised number of wait states, performs a big-endian byte/halfword/word access to an internal byte-addressed RAM, and signals completion on MOC. It sits between MAR/MDR and the microsequencer's MOC condition input, replacing the constant-tied MOC used so far.

## Interface
- ADDR_WIDTH, 9: RAM holds 2^ADDR_WIDTH bytes; only Address[ADDR_WIDTH-1:0] is used.
- WAIT_CYCLES, 2: wait states inserted before the access; legal range 0..15.
- Clk  input  1  clock; all state changes on posedge.
- Clr  input  1  reset; synchronous, active-high.
- MOV  input  1  memory operation valid, from the control register.
- RW  input  1  1 = read, 0 = write; same encoding as the control-word RW field.
- Address  input  32  byte address, from MAR.
- DataIn  input  32  write data, from MDR.
- Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- SignExt  input  1  reads only: 1 = sign-extend, 0 = zero-extend.
- DataOut  output  32  read data; valid while MOC = 1 and RW was 1.
- MOC  output  1  memory operation complete.
- Err  output  1  alignment/size error; valid only while MOC = 1.

## Operation
- Registered outputs. Reset values: MOC = 0, Err = 0, DataOut = 32'h0, state = IDLE, wait counter = 0. RAM contents are not cleared by Clr.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: if MOV = 1 at a posedge, latch RW, Address[ADDR_WIDTH-1:0], DataIn, Size and SignExt. Load the counter with WAIT_CYCLES. Go to WAIT, or go straight to ACCESS when WAIT_CYCLES = 0.
- WAIT: decrement the counter each edge. Go to ACCESS on the edge where the counter reaches 0. Inputs are ignored; only latched values are used.
- ACCESS: check alignment. Halfword requires addr[0] = 0. Word requires addr[1:0] = 0. Size 11 is always an error.
  - On error: RAM is untouched, Err = 1, DataOut = 0.
  - Otherwise perform the access: Err = 0.
  - In all cases go to DONE with MOC = 1.
- Write, big-endian:
  - Byte: mem[a] = D[7:0].
  - Halfword: mem[a] = D[15:8], mem[a+1] = D[7:0].
  - Word: mem[a..a+3] = D[31:24], D[23:16], D[15:8], D[7:0].
  - DataOut = 0 after any write.
- Read: the same byte ordering is packed right-justified into DataOut. Upper bits are filled with the MSB of the fetched item if SignExt = 1, otherwise with 0. Word reads ignore SignExt.
- DONE: hold MOC, Err and DataOut stable while MOV = 1. On the first edge with MOV = 0, go to IDLE with MOC = 0 and Err = 0. DataOut holds its last value.
- MOV dropped during WAIT or ACCESS does not abort the request; it completes normally. MOC is then high for exactly one cycle, since DONE sees MOV = 0 on its first edge.
- Back-to-back requests: the initiator must sample MOC = 1, then drop MOV for at least one edge. A new request is accepted only in IDLE.
- Address wrap: a + k is computed modulo 2^ADDR_WIDTH. Aligned accesses never wrap inside a single item.
- Clr = 1 at any edge forces the reset values and IDLE. A write that has not yet reached ACCESS is discarded. A write already performed in ACCESS remains in RAM.
- Clr has priority over MOV at the same edge.

## Timing
- MOV sampled 1 in IDLE at edge k: the access occurs at edge k+WAIT_CYCLES+1, and MOC rises after that edge.
- With WAIT_CYCLES = 0, MOC rises after edge k+1, so latency is 2 edges.
- MOC falls after the first edge at which MOV = 0 is sampled in DONE.
- Minimum request-to-request spacing is WAIT_CYCLES + 3 cycles.
- DataOut and Err change only on the ACCESS→DONE transition and on reset.

## Test plan
- Word write then read, WAIT_CYCLES = 2: write 32'hDEADBEEF at 0x010, then read word at 0x010 → DataOut = 32'hDEADBEEF, Err = 0. MOC rises exactly 3 edges after each MOV sample; the byte read at 0x010 returns 32'h000000DE.
- Sign extension: byte read at 0x013 (holds 0xEF) → 32'hFFFFFFEF with SignExt = 1, 32'h000000EF with SignExt = 0. Halfword read at 0x012 with SignExt = 1 → 32'hFFFFBEEF.
- Misalignment: word write of 32'h12345678 at 0x021 → MOC = 1, Err = 1, DataOut = 0; a following word read at 0x020 shows unchanged contents. Size = 11 → Err = 1.
- Handshake: hold MOV = 1 for 5 cycles after MOC rises → MOC and DataOut stay stable the whole time. Drop MOV during WAIT → MOC is a one-cycle pulse, and the write still lands.
- Reset mid-operation: start a word write to 0x030, assert Clr during WAIT → MOC = 0, Err = 0, DataOut = 0 next cycle; a later read of 0x030 shows the old contents. A new request after Clr deasserts completes normally.
- Wrap and zero wait: with WAIT_CYCLES = 0 and ADDR_WIDTH = 9, write byte 0xA5 at Address 32'h0000_0200 → a read at 0x000 returns 32'h000000A5, with MOC 2 edges after MOV.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath (MAR/MDR/control word)
// and the memory responder. The initiator drives the request side; the
// responder returns read data, completion and error status.
interface mem_responder_if;
    logic        MOV;
    logic        RW;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Err;

    modport master (
        output MOV, RW, Address, DataIn, Size, SignExt,
        input  DataOut, MOC, Err
    );

    modport slave (
        input  MOV, RW, Address, DataIn, Size, SignExt,
        output DataOut, MOC, Err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the MOV/RW/MOC handshake: latches a request,
// waits WAIT_CYCLES states, then performs a big-endian byte/halfword/word
// access on an internal byte-addressed RAM and raises MOC until MOV drops.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Clr,
    mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  sext_q, sext_d;
    logic [31:0]           dout_q, dout_d;
    logic                  moc_q, moc_d;
    logic                  err_q, err_d;

    logic [7:0]            mem [DEPTH];

    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic                  misalign;
    logic [31:0]           rdata;
    logic                  do_write;

    // Upper address bits are beyond the RAM and intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.Address[31:ADDR_WIDTH];

    assign bus.DataOut = dout_q;
    assign bus.MOC     = moc_q;
    assign bus.Err     = err_q;

    // Byte addresses of the item (wrapping modulo RAM size), fetched bytes,
    // alignment check and right-justified, optionally sign-extended read data.
    always_comb begin
        a0 = addr_q;
        a1 = addr_q + ADDR_WIDTH'(1);
        a2 = addr_q + ADDR_WIDTH'(2);
        a3 = addr_q + ADDR_WIDTH'(3);
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        misalign = 1'b0;
        rdata    = 32'h0;
        case (size_q)
            SZ_BYTE: begin
                rdata = {{24{sext_q & b0[7]}}, b0};
            end
            SZ_HALF: begin
                misalign = addr_q[0];
                rdata    = {{16{sext_q & b0[7]}}, b0, b1};
            end
            SZ_WORD: begin
                misalign = (addr_q[1:0] != 2'b00);
                rdata    = {b0, b1, b2, b3};
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
        do_write = (state_q == ST_ACCESS) && !rw_q && !misalign && !Clr;
    end

    // Handshake FSM: latch the request in IDLE, count wait states, do the
    // access and register the result, then hold it until MOV is released.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sext_d  = sext_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.MOV) begin
                    rw_d    = bus.RW;
                    addr_d  = bus.Address[ADDR_WIDTH-1:0];
                    wdata_d = bus.DataIn;
                    size_d  = bus.Size;
                    sext_d  = bus.SignExt;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                moc_d   = 1'b1;
                err_d   = misalign;
                dout_d  = (!misalign && rw_q) ? rdata : 32'h0;
                state_d = ST_DONE;
            end
            default: begin
                if (!bus.MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Control/result registers with synchronous reset; Clr beats MOV.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    // Big-endian RAM write in ACCESS; contents survive reset.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            case (size_q)
                SZ_BYTE: begin
                    mem[a0] <= wdata_q[7:0];
                end
                SZ_HALF: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                default: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of read/write requests on a
// two-wait-state instance, plus hand sequences for hold, early MOV drop,
// mid-operation reset and a zero-wait instance with address wrap.
module tb_mem_responder;

    localparam int AW     = 9;
    localparam int W_SLOW = 2;
    localparam int W_FAST = 0;
    localparam int NVEC   = 17;

    logic        clk = 1'b0;
    logic        clr;
    logic        mov_slow, mov_fast;
    logic        rw, sext;
    logic [31:0] addr, din;
    logic [1:0]  size;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_responder_if bus_slow();
    mem_responder_if bus_fast();

    assign bus_slow.MOV     = mov_slow;
    assign bus_slow.RW      = rw;
    assign bus_slow.Address = addr;
    assign bus_slow.DataIn  = din;
    assign bus_slow.Size    = size;
    assign bus_slow.SignExt = sext;

    assign bus_fast.MOV     = mov_fast;
    assign bus_fast.RW      = rw;
    assign bus_fast.Address = addr;
    assign bus_fast.DataIn  = din;
    assign bus_fast.Size    = size;
    assign bus_fast.SignExt = sext;

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W_SLOW)) dut_slow (
        .Clk (clk),
        .Clr (clr),
        .bus (bus_slow.slave)
    );

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W_FAST)) dut_fast (
        .Clk (clk),
        .Clr (clr),
        .bus (bus_fast.slave)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sext;
        logic        exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic cur_moc(input logic fast);
        return fast ? bus_fast.MOC : bus_slow.MOC;
    endfunction

    function automatic logic cur_err(input logic fast);
        return fast ? bus_fast.Err : bus_slow.Err;
    endfunction

    function automatic logic [31:0] cur_dout(input logic fast);
        return fast ? bus_fast.DataOut : bus_slow.DataOut;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic apply_stimulus(input logic fast, input logic r, input logic [31:0] a,
                                  input logic [31:0] d, input logic [1:0] s,
                                  input logic se);
        rw   = r;
        addr = a;
        din  = d;
        size = s;
        sext = se;
        if (fast) mov_fast = 1'b1;
        else      mov_slow = 1'b1;
    endtask

    task automatic release_mov();
        mov_slow = 1'b0;
        mov_fast = 1'b0;
    endtask

    // Wait (bounded) for MOC after the sampling edge; returns edges counted.
    task automatic wait_moc(input logic fast, output int lat);
        lat = 0;
        while (!cur_moc(fast) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Full request: sample edge, latency, result, then release and MOC drop.
    task automatic do_req(input string tag, input logic fast, input logic r,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic se,
                          input logic exp_err, input logic [31:0] exp_dout);
        int lat;
        apply_stimulus(fast, r, a, d, s, se);
        tick();
        wait_moc(fast, lat);
        check_output({tag, " latency"}, 32'(lat), fast ? 32'(W_FAST + 1) : 32'(W_SLOW + 1));
        check_output({tag, " err"}, {31'h0, cur_err(fast)}, {31'h0, exp_err});
        check_output({tag, " dout"}, cur_dout(fast), exp_dout);
        release_mov();
        tick();
        check_output({tag, " moc_fall"}, {31'h0, cur_moc(fast)}, 32'h0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{1'b0, 32'h010, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h010, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h010, 32'h0,        2'b00, 1'b0, 1'b0, 32'h000000DE};
        vecs[3]  = '{1'b1, 32'h013, 32'h0,        2'b00, 1'b1, 1'b0, 32'hFFFFFFEF};
        vecs[4]  = '{1'b1, 32'h013, 32'h0,        2'b00, 1'b0, 1'b0, 32'h000000EF};
        vecs[5]  = '{1'b1, 32'h012, 32'h0,        2'b01, 1'b1, 1'b0, 32'hFFFFBEEF};
        vecs[6]  = '{1'b1, 32'h010, 32'h0,        2'b01, 1'b1, 1'b0, 32'hFFFFDEAD};
        vecs[7]  = '{1'b1, 32'h010, 32'h0,        2'b01, 1'b0, 1'b0, 32'h0000DEAD};
        vecs[8]  = '{1'b0, 32'h020, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h021, 32'h12345678, 2'b10, 1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 32'h020, 32'h0,        2'b10, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 32'h020, 32'h0,        2'b11, 1'b0, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 32'h023, 32'h00001111, 2'b01, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 32'h024, 32'h00000000, 2'b10, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h024, 32'h0000ABCD, 2'b01, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 32'h024, 32'h0,        2'b10, 1'b1, 1'b0, 32'hABCD0000};
        vecs[16] = '{1'b1, 32'h020, 32'h0,        2'b10, 1'b0, 1'b0, 32'hCAFEF00D};

        clr      = 1'b1;
        mov_slow = 1'b0;
        mov_fast = 1'b0;
        rw       = 1'b0;
        sext     = 1'b0;
        addr     = 32'h0;
        din      = 32'h0;
        size     = 2'b00;
        tick();
        tick();
        clr = 1'b0;

        check_output("reset moc slow",  {31'h0, bus_slow.MOC}, 32'h0);
        check_output("reset err slow",  {31'h0, bus_slow.Err}, 32'h0);
        check_output("reset dout slow", bus_slow.DataOut, 32'h0);
        check_output("reset moc fast",  {31'h0, bus_fast.MOC}, 32'h0);
        check_output("reset dout fast", bus_fast.DataOut, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            do_req($sformatf("vec%0d", i), 1'b0, vecs[i].rw, vecs[i].addr, vecs[i].din,
                   vecs[i].size, vecs[i].sext, vecs[i].exp_err, vecs[i].exp_dout);
        end

        // Hold MOV for five cycles after MOC: outputs must stay put.
        apply_stimulus(1'b0, 1'b1, 32'h010, 32'h0, 2'b10, 1'b0);
        tick();
        wait_moc(1'b0, lat);
        check_output("hold latency", 32'(lat), 32'(W_SLOW + 1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("hold moc %0d", i), {31'h0, bus_slow.MOC}, 32'h1);
            check_output($sformatf("hold dout %0d", i), bus_slow.DataOut, 32'hDEADBEEF);
        end
        release_mov();
        tick();
        check_output("hold release moc", {31'h0, bus_slow.MOC}, 32'h0);
        check_output("hold release dout", bus_slow.DataOut, 32'hDEADBEEF);

        // MOV dropped during WAIT: request completes, MOC is a single pulse.
        apply_stimulus(1'b0, 1'b0, 32'h040, 32'h55AA33CC, 2'b10, 1'b0);
        tick();
        release_mov();
        wait_moc(1'b0, lat);
        check_output("early drop latency", 32'(lat), 32'(W_SLOW + 1));
        check_output("early drop err", {31'h0, bus_slow.Err}, 32'h0);
        tick();
        check_output("early drop pulse", {31'h0, bus_slow.MOC}, 32'h0);
        do_req("early drop readback", 1'b0, 1'b1, 32'h040, 32'h0, 2'b10, 1'b0, 1'b0, 32'h55AA33CC);

        // Clr during WAIT discards the pending write and clears outputs.
        do_req("pre-reset write", 1'b0, 1'b0, 32'h030, 32'h0BADF00D, 2'b10, 1'b0, 1'b0, 32'h0);
        do_req("pre-reset read", 1'b0, 1'b1, 32'h030, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0BADF00D);
        apply_stimulus(1'b0, 1'b0, 32'h030, 32'hFFFFFFFF, 2'b10, 1'b0);
        tick();
        clr = 1'b1;
        tick();
        check_output("mid reset moc",  {31'h0, bus_slow.MOC}, 32'h0);
        check_output("mid reset err",  {31'h0, bus_slow.Err}, 32'h0);
        check_output("mid reset dout", bus_slow.DataOut, 32'h0);
        tick();
        check_output("reset beats mov", {31'h0, bus_slow.MOC}, 32'h0);
        clr = 1'b0;
        release_mov();
        tick();
        do_req("post-reset read", 1'b0, 1'b1, 32'h030, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0BADF00D);

        // Zero-wait instance: byte write at 0x200 wraps to 0x000.
        do_req("fast wrap write", 1'b1, 1'b0, 32'h0000_0200, 32'h000000A5, 2'b00, 1'b0, 1'b0, 32'h0);
        do_req("fast wrap read", 1'b1, 1'b1, 32'h0000_0000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h000000A5);
        do_req("fast sext read", 1'b1, 1'b1, 32'h0000_0000, 32'h0, 2'b00, 1'b1, 1'b0, 32'hFFFFFFA5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
